mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 14: byte-address width of the shared memory (depth 2**ADDR_WIDTH bytes).
REQ-002 i_clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 i_host_req  in  1  host byte-access request; held with i_host_we/addr/wdata until o_host_ack.
REQ-005 i_host_we  in  1  1 = write, 0 = read.
REQ-006 i_host_addr  in  ADDR_WIDTH  host byte address.
REQ-007 i_host_wdata  in  8  host write byte.
REQ-008 o_host_ack  out  1  one-cycle completion pulse.
REQ-009 o_host_rdata  out  8  read byte; valid while o_host_ack=1, held until next host read.
REQ-010 i_cpu_req  in  1  CPU word-access request; held with i_cpu_we/addr/wdata until o_cpu_ack.
REQ-011 i_cpu_we  in  1  1 = write, 0 = read.
REQ-012 i_cpu_addr  in  32  CPU byte address; only [ADDR_WIDTH-1:0] used.
REQ-013 i_cpu_wdata  in  32  little-endian write word.
REQ-014 o_cpu_ack  out  1  one-cycle completion pulse.
REQ-015 o_cpu_rdata  out  32  little-endian read word; valid while o_cpu_ack=1, held until next CPU read.
REQ-016 o_mem_en, o_mem_we  out  1 each  memory strobe and write enable.
REQ-017 o_mem_addr  out  ADDR_WIDTH; o_mem_wdata  out  8  memory address and write byte.
REQ-018 i_mem_rdata  in  8  memory read byte, valid the cycle after o_mem_en with o_mem_we=0.

Function
REQ-019 FSM states: IDLE, HOST_ACC, CPU_ACC, CAP, DONE.
REQ-020 IDLE: ignore any requester whose ack is high this cycle; one eligible req -> grant it; both -> grant the one not served last (r_last_cpu).
REQ-021 Host grant: HOST_ACC (1 cycle: o_mem_en=1, we/addr/wdata from host) -> CAP -> DONE.
REQ-022 CPU grant: CPU_ACC for 4 cycles, beat b=0..3: o_mem_addr=(i_cpu_addr[ADDR_WIDTH-1:0]+b) mod 2**ADDR_WIDTH, o_mem_wdata=i_cpu_wdata[8b+7:8b]; then CAP -> DONE.
REQ-023 Read capture: beat b byte taken from i_mem_rdata the cycle after beat b issues; last byte captured in CAP; o_*_rdata updated at end of CAP.
REQ-024 DONE: granted requester's ack=1 for exactly one cycle; r_last_cpu updated; next state IDLE.
REQ-025 Latency req-high-in-IDLE to ack: host 3 cycles, CPU 6 cycles, read or write alike.
REQ-026 o_mem_en=0 in IDLE, CAP, DONE; never more than one requester's signals on the memory port.
REQ-027 Requester dropping req mid-transaction: transaction still completes and acks.
REQ-028 Address wrap at top of memory within a CPU word is legal, no error.
REQ-029 Non-granted requester is never acked and its req is not latched.

Reset
REQ-030 Asserting i_rst_n=0 shall immediately force state IDLE, o_host_ack=o_cpu_ack=0, o_mem_en=o_mem_we=0, r_last_cpu=0 (CPU wins first contention), beat counter 0, o_host_rdata=0, o_cpu_rdata=0.
REQ-031 Reset mid-transaction aborts it with no ack; partially written CPU bytes remain written.

Structure
REQ-032 Package mem_arbiter_pkg holds the state enum and constant CPU_BEATS=4.
REQ-033 One sub-module, rr_arb2 (2-way round-robin grant with last-served flag), is natural; rest is inline.

Verification
REQ-034 Host write 0x5A to 0x0010, then host read 0x0010 -> ack 3 cycles after each req, o_host_rdata=0x5A.
REQ-035 CPU write 0xDEADBEEF at 0x0100 -> mem bytes 0x100..0x103 = EF,BE,AD,DE; CPU read -> o_cpu_rdata=0xDEADBEEF, ack 6 cycles after req.
REQ-036 Host and CPU req same cycle after reset -> CPU granted first, host acked after CPU; repeat with both held -> alternates host, CPU.
REQ-037 CPU write 0x11223344 at 0x3FFE -> bytes 0x3FFE=44, 0x3FFF=33, 0x0000=22, 0x0001=11.
REQ-038 i_rst_n low during CPU_ACC beat 2 -> no ack, o_mem_en=0 same cycle, bytes beat 0-1 written, beats 2-3 not.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the host/CPU memory arbiter: FSM state codes and
// the number of byte beats that make up one CPU word access.
package mem_arbiter_pkg;

    localparam int CPU_BEATS = 4;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_HOST_ACC = 3'd1;
    localparam state_t S_CPU_ACC  = 3'd2;
    localparam state_t S_CAP      = 3'd3;
    localparam state_t S_DONE     = 3'd4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the host byte port, the CPU word port and the byte-wide memory
// port. The arbiter uses the slave view; requesters and memory use master.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 14
) ();

    logic                  i_host_req;
    logic                  i_host_we;
    logic [ADDR_WIDTH-1:0] i_host_addr;
    logic [7:0]            i_host_wdata;
    logic                  o_host_ack;
    logic [7:0]            o_host_rdata;

    logic                  i_cpu_req;
    logic                  i_cpu_we;
    logic [31:0]           i_cpu_addr;
    logic [31:0]           i_cpu_wdata;
    logic                  o_cpu_ack;
    logic [31:0]           o_cpu_rdata;

    logic                  o_mem_en;
    logic                  o_mem_we;
    logic [ADDR_WIDTH-1:0] o_mem_addr;
    logic [7:0]            o_mem_wdata;
    logic [7:0]            i_mem_rdata;

    modport slave (
        input  i_host_req, i_host_we, i_host_addr, i_host_wdata,
        output o_host_ack, o_host_rdata,
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output o_cpu_ack, o_cpu_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_host_req, i_host_we, i_host_addr, i_host_wdata,
        input  o_host_ack, o_host_rdata,
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  o_cpu_ack, o_cpu_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant between host and CPU. A single last-served flag
// decides contention; it clears to 0 so the CPU wins the first tie.
module rr_arb2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req_host,
    input  logic i_req_cpu,
    input  logic i_update,
    input  logic i_served_cpu,
    output logic o_gnt_host,
    output logic o_gnt_cpu
);

    logic r_last_cpu;

    // Remember who finished most recently so the other side wins the next tie
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_cpu <= 1'b0;
        end else if (i_update) begin
            r_last_cpu <= i_served_cpu;
        end
    end

    assign o_gnt_cpu  = i_req_cpu  & (~i_req_host | ~r_last_cpu);
    assign o_gnt_host = i_req_host & (~i_req_cpu  |  r_last_cpu);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a byte-wide memory between a host byte port and a CPU word port.
// A CPU word is moved as four little-endian byte beats; read bytes arrive one
// cycle after their beat and are assembled before the single-cycle ack.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mem_arbiter_if.slave   bus
);

    state_t                r_state;
    logic [1:0]            r_beat;
    logic                  r_gnt_cpu;
    logic                  r_read;
    logic [23:0]           r_cap;
    logic [7:0]            r_host_rdata;
    logic [31:0]           r_cpu_rdata;

    logic                  w_host_elig;
    logic                  w_cpu_elig;
    logic                  w_gnt_host;
    logic                  w_gnt_cpu;
    logic                  w_host_acc;
    logic                  w_cpu_acc;
    logic                  w_done;
    logic [ADDR_WIDTH-1:0] w_cpu_addr;
    logic [7:0]            w_cpu_byte;
    logic                  w_unused_addr;

    assign w_unused_addr = ^bus.i_cpu_addr[31:ADDR_WIDTH];

    assign w_host_acc = (r_state == S_HOST_ACC);
    assign w_cpu_acc  = (r_state == S_CPU_ACC);
    assign w_done     = (r_state == S_DONE);

    assign w_host_elig = bus.i_host_req & ~bus.o_host_ack;
    assign w_cpu_elig  = bus.i_cpu_req  & ~bus.o_cpu_ack;

    rr_arb2 u_rr_arb2 (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req_host   (w_host_elig),
        .i_req_cpu    (w_cpu_elig),
        .i_update     (w_done),
        .i_served_cpu (r_gnt_cpu),
        .o_gnt_host   (w_gnt_host),
        .o_gnt_cpu    (w_gnt_cpu)
    );

    assign w_cpu_addr = bus.i_cpu_addr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(r_beat);
    assign w_cpu_byte = bus.i_cpu_wdata[{r_beat, 3'b000} +: 8];

    assign bus.o_mem_en    = w_host_acc | w_cpu_acc;
    assign bus.o_mem_we    = w_host_acc ? bus.i_host_we :
                             w_cpu_acc  ? bus.i_cpu_we  : 1'b0;
    assign bus.o_mem_addr  = w_cpu_acc  ? w_cpu_addr       :
                             w_host_acc ? bus.i_host_addr  : '0;
    assign bus.o_mem_wdata = w_cpu_acc  ? w_cpu_byte       :
                             w_host_acc ? bus.i_host_wdata : 8'h00;

    assign bus.o_host_ack   = w_done & ~r_gnt_cpu;
    assign bus.o_cpu_ack    = w_done &  r_gnt_cpu;
    assign bus.o_host_rdata = r_host_rdata;
    assign bus.o_cpu_rdata  = r_cpu_rdata;

    // Main sequencer: grant, issue beats, collect read bytes, then ack once
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_beat       <= 2'd0;
            r_gnt_cpu    <= 1'b0;
            r_read       <= 1'b0;
            r_cap        <= 24'h0;
            r_host_rdata <= 8'h00;
            r_cpu_rdata  <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_cpu) begin
                        r_gnt_cpu <= 1'b1;
                        r_read    <= ~bus.i_cpu_we;
                        r_beat    <= 2'd0;
                        r_state   <= S_CPU_ACC;
                    end else if (w_gnt_host) begin
                        r_gnt_cpu <= 1'b0;
                        r_read    <= ~bus.i_host_we;
                        r_state   <= S_HOST_ACC;
                    end
                end
                S_HOST_ACC: begin
                    r_state <= S_CAP;
                end
                S_CPU_ACC: begin
                    case (r_beat)
                        2'd1:    r_cap[7:0]   <= bus.i_mem_rdata;
                        2'd2:    r_cap[15:8]  <= bus.i_mem_rdata;
                        2'd3:    r_cap[23:16] <= bus.i_mem_rdata;
                        default: ;
                    endcase
                    if (r_beat == 2'(CPU_BEATS - 1)) begin
                        r_beat  <= 2'd0;
                        r_state <= S_CAP;
                    end else begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                S_CAP: begin
                    if (r_read && r_gnt_cpu) begin
                        r_cpu_rdata <= {bus.i_mem_rdata, r_cap};
                    end else if (r_read) begin
                        r_host_rdata <= bus.i_mem_rdata;
                    end
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural byte memory attached.
module tb_mem_arbiter;

   localparam int AW = 14;

   logic clk = 1'b0;
   logic rstN = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

   mem_arbiter #(.ADDR_WIDTH(AW)) dut (
      .i_clk   (clk),
      .i_rst_n (rstN),
      .bus     (bus.slave)
   );

   logic [7:0] mem [0:(1<<AW)-1];
   int total = 0;
   int bad = 0;

   // Byte memory: writes land on the edge, reads return one cycle later
   always @(posedge clk) begin
      if (bus.o_mem_en && bus.o_mem_we)
         mem[bus.o_mem_addr] <= bus.o_mem_wdata;
      if (bus.o_mem_en && !bus.o_mem_we)
         bus.i_mem_rdata <= mem[bus.o_mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // One complete request on either port; returns cycles to ack and read data
   task automatic applyStimulus(input bit isCpu, input bit we, input logic [31:0] addr,
                                input logic [31:0] wdata, output int latency, output logic [31:0] rdata);
      @(posedge clk); #1;
      if (isCpu) begin
         bus.i_cpu_we = we; bus.i_cpu_addr = addr; bus.i_cpu_wdata = wdata; bus.i_cpu_req = 1'b1;
      end else begin
         bus.i_host_we = we; bus.i_host_addr = addr[AW-1:0]; bus.i_host_wdata = wdata[7:0]; bus.i_host_req = 1'b1;
      end
      latency = 0;
      rdata = 32'h0;
      forever begin
         @(posedge clk); #1;
         latency++;
         if (isCpu ? bus.o_cpu_ack : bus.o_host_ack) begin
            rdata = isCpu ? bus.o_cpu_rdata : {24'h0, bus.o_host_rdata};
            break;
         end
         if (latency >= 20) begin
            checkOutput("ack_timeout", 32'd0, 32'd1);
            break;
         end
      end
      bus.i_cpu_req = 1'b0;
      bus.i_host_req = 1'b0;
   endtask

   int lat;
   logic [31:0] rd;
   logic [31:0] word;
   logic [1:0] expAck;
   bit ackSeen;

   initial begin
      bus.i_host_req = 0; bus.i_host_we = 0; bus.i_host_addr = '0; bus.i_host_wdata = '0;
      bus.i_cpu_req = 0; bus.i_cpu_we = 0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;

      #2 rstN = 1'b0;
      #1;
      checkOutput("rst_host_ack", {31'h0, bus.o_host_ack}, 32'd0);
      checkOutput("rst_cpu_ack", {31'h0, bus.o_cpu_ack}, 32'd0);
      checkOutput("rst_mem_en", {31'h0, bus.o_mem_en}, 32'd0);
      checkOutput("rst_mem_we", {31'h0, bus.o_mem_we}, 32'd0);
      checkOutput("rst_host_rdata", {24'h0, bus.o_host_rdata}, 32'd0);
      checkOutput("rst_cpu_rdata", bus.o_cpu_rdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rstN = 1'b1;

      applyStimulus(0, 1, 32'h0010, 32'h5A, lat, rd);
      checkOutput("host_wr_lat", lat, 3);
      checkOutput("host_wr_mem", {24'h0, mem[14'h0010]}, 32'h5A);
      applyStimulus(0, 0, 32'h0010, 32'h0, lat, rd);
      checkOutput("host_rd_lat", lat, 3);
      checkOutput("host_rd_data", rd, 32'h5A);

      applyStimulus(1, 1, 32'h0100, 32'hDEADBEEF, lat, rd);
      checkOutput("cpu_wr_lat", lat, 6);
      word = 32'hDEADBEEF;
      for (int i = 0; i < 4; i++)
         checkOutput($sformatf("cpu_wr_byte%0d", i), {24'h0, mem[14'h0100 + 14'(i)]}, {24'h0, word[8*i +: 8]});
      applyStimulus(1, 0, 32'h0100, 32'h0, lat, rd);
      checkOutput("cpu_rd_lat", lat, 6);
      checkOutput("cpu_rd_data", rd, 32'hDEADBEEF);
      checkOutput("host_rdata_held", {24'h0, bus.o_host_rdata}, 32'h5A);

      applyStimulus(1, 1, 32'h3FFE, 32'h11223344, lat, rd);
      checkOutput("wrap_3ffe", {24'h0, mem[14'h3FFE]}, 32'h44);
      checkOutput("wrap_3fff", {24'h0, mem[14'h3FFF]}, 32'h33);
      checkOutput("wrap_0000", {24'h0, mem[14'h0000]}, 32'h22);
      checkOutput("wrap_0001", {24'h0, mem[14'h0001]}, 32'h11);
      applyStimulus(1, 0, 32'h3FFE, 32'h0, lat, rd);
      checkOutput("wrap_rd_data", rd, 32'h11223344);

      applyStimulus(1, 1, 32'h0200, 32'h0, lat, rd);
      @(posedge clk); #1;
      bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 32'h0200; bus.i_cpu_wdata = 32'hA1B2C3D4; bus.i_cpu_req = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      checkOutput("abort_beat2_en", {31'h0, bus.o_mem_en}, 32'd1);
      checkOutput("abort_beat2_addr", {18'h0, bus.o_mem_addr}, 32'h0202);
      rstN = 1'b0;
      #1;
      checkOutput("abort_mem_en", {31'h0, bus.o_mem_en}, 32'd0);
      checkOutput("abort_cpu_rdata", bus.o_cpu_rdata, 32'd0);
      ackSeen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         ackSeen = ackSeen | bus.o_cpu_ack | bus.o_host_ack;
      end
      bus.i_cpu_req = 1'b0;
      @(negedge clk) rstN = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         ackSeen = ackSeen | bus.o_cpu_ack | bus.o_host_ack;
      end
      checkOutput("abort_no_ack", {31'h0, ackSeen}, 32'd0);
      checkOutput("abort_byte0", {24'h0, mem[14'h0200]}, 32'hD4);
      checkOutput("abort_byte1", {24'h0, mem[14'h0201]}, 32'hC3);
      checkOutput("abort_byte2", {24'h0, mem[14'h0202]}, 32'h00);
      checkOutput("abort_byte3", {24'h0, mem[14'h0203]}, 32'h00);

      bus.i_host_we = 1'b1; bus.i_host_addr = 14'h0020; bus.i_host_wdata = 8'h77;
      bus.i_cpu_we = 1'b1; bus.i_cpu_addr = 32'h0300; bus.i_cpu_wdata = 32'h01020304;
      bus.i_host_req = 1'b1; bus.i_cpu_req = 1'b1;
      for (int n = 1; n <= 21; n++) begin
         @(posedge clk); #1;
         expAck = (n == 6 || n == 17) ? 2'b10 : (n == 10 || n == 21) ? 2'b01 : 2'b00;
         checkOutput($sformatf("arb_ack_c%0d", n), {30'h0, bus.o_cpu_ack, bus.o_host_ack}, {30'h0, expAck});
      end
      bus.i_host_req = 1'b0; bus.i_cpu_req = 1'b0;
      @(posedge clk); #1;
      checkOutput("arb_host_mem", {24'h0, mem[14'h0020]}, 32'h77);
      checkOutput("arb_cpu_mem", {mem[14'h0303], mem[14'h0302], mem[14'h0301], mem[14'h0300]}, 32'h01020304);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
